sample_pwm_dac: RTL and testbench
=================================

# sample_pwm_dac

Output stage of the speech synthesis path: a sample-period timer plus a double-buffered 8-bit PWM DAC. It generates the `period_expired` tick that paces the main sequencer FSM and accepts each ROM sample on the FSM's `sample_capture` strobe. It presents each sample to the PWM modulator at the next period boundary and drives the audio PWM pin and amplifier enable.

## Interface
- `SAMPLE_DIV`, 12500, clocks per sample period (100 MHz / 8 kHz); legal range ≥ 16.
- `PWM_BITS`, 8, sample and PWM resolution.
- `MIDSCALE`, 2^(PWM_BITS-1), idle/reset sample value (0x80).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_in`  in  PWM_BITS  ROM sample data, valid when `sample_capture`=1.
- `sample_capture`  in  1  one-cycle strobe from sequencer FSM; load `sample_in` into the hold register.
- `busy`  in  1  sequencer busy flag, meaning an utterance is in progress.
- `underrun_clr`  in  1  clears the sticky `underrun` flag.
- `period_expired`  out  1  registered one-cycle tick, once per `SAMPLE_DIV` clocks.
- `pwm_out`  out  1  registered PWM audio output.
- `amp_en`  out  1  audio amplifier enable (active high).
- `underrun`  out  1  sticky: a period boundary passed during `busy` with no fresh sample.

## Operation
- **Reset values:** `period_cnt`=0, `period_expired`=0, `hold`=MIDSCALE, `hold_valid`=0, `active`=MIDSCALE, `duty`=MIDSCALE, `pwm_cnt`=0, `pwm_out`=0, `amp_en`=0, `underrun`=0.
- **Period timer:**
  - `period_cnt` counts 0..SAMPLE_DIV-1 and wraps to 0. It is free-running, independent of `busy`.
  - `period_expired` is registered high for exactly the cycle after `period_cnt`=SAMPLE_DIV-1.
- **Capture:** on `sample_capture`=1, `hold` ← `sample_in` and `hold_valid` ← 1.
- **Transfer, in the cycle `period_expired`=1:**
  - If `hold_valid`=1: `active` ← `hold` and `hold_valid` ← 0.
  - Else if `busy`=1: `active` is unchanged (repeat the previous sample) and `underrun` ← 1.
  - Else (idle): `active` ← MIDSCALE.
- **Simultaneous `sample_capture` and `period_expired`:**
  - The transfer uses the pre-edge `hold` contents.
  - The new sample lands in `hold` with `hold_valid`=1, so it is not lost and plays next period.
  - If the pre-edge `hold_valid` was 0, the underrun rule above still applies.
- **Capture while `hold_valid`=1:** the new sample overwrites `hold`. No error is flagged, since the sequencer guarantees at most one capture per period.
- **PWM:**
  - `pwm_cnt` is a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0.
  - When `pwm_cnt`=2^PWM_BITS-1, `duty` ← `active`. This gives glitch-free updates at the PWM frame boundary only.
  - `pwm_out` ← (`pwm_cnt` < `duty`), unsigned compare.
  - `duty`=0 gives constant low; `duty`=255 gives high 255 of every 256 clocks.
- **Amplifier:**
  - `amp_en` ← 1 on any cycle with `busy`=1.
  - `amp_en` ← 0 at the first `period_expired` with `busy`=0, after the transfer. The last sample therefore plays one full period before shutdown.
- **Underrun flag:** `underrun_clr` clears `underrun`. A set event in the same cycle wins.

## Timing
- `sample_capture` at edge N puts the sample in `hold` at N+1.
- The sample reaches `active` at the next `period_expired` edge.
- It reaches `duty` at the following PWM wrap, at most 2^PWM_BITS clocks later.
- It is visible on `pwm_out` one clock after that.
- `period_expired` spacing is exactly SAMPLE_DIV clocks from reset release. The first pulse occurs SAMPLE_DIV clocks after `rst_n` deasserts.
- Asserting `rst_n` mid-operation immediately forces all registers to their reset values, including `pwm_out`=0 and `amp_en`=0.

## Structure
- **Shared speech package:** `SAMPLE_DIV`, `PWM_BITS`, `MIDSCALE`, and the sample width type, shared with the sequencer and sample ROM.
- **Sub-module `pwm_gen`:** PWM counter, `duty` register with wrap-load, and comparator. Ports: `clk`, `rst_n`, `active`, `pwm_out`.
- **Top level:** the timer, hold/active double buffer, underrun logic and amplifier control.

## Test plan
All scenarios use SAMPLE_DIV=600 and PWM_BITS=8.
- **Reset, no stimulus:** `period_expired` pulses at cycles 600, 1200 and 1800 after release, one cycle wide. `pwm_out` duty is 128/256 and `amp_en`=0.
- **Single sample:** `busy`=1, capture 0x40 at cycle 100. `active`=0x40 after the 600 tick, and `pwm_out` is high for 64 of 256 clocks from the next PWM frame.
- **Extremes:** capture 0x00, then 0xFF one period later. `pwm_out` is constantly low, then high for 255 of 256 clocks.
- **Underrun:** `busy`=1 with no capture before the tick. `underrun`=1 and `active` holds its previous value. `underrun_clr` returns `underrun` to 0.
- **Collision:** `sample_capture` (0x10) coincides with `period_expired` while `hold`=0x20 is valid. `active`=0x20, and `hold`=0x10 is valid and transfers at the next tick.
- **Shutdown and reset:** `busy` falls. `amp_en` stays 1 until the next tick, then goes to 0 with `active`=0x80. Asserting `rst_n` mid-frame forces `pwm_out`=0 asynchronously.

Source files
------------

// File: rtl/sample_pwm_dac_pkg.sv
// Shared speech-path constants and sample type, used by the sequencer, ROM and DAC.
package sample_pwm_dac_pkg;

   localparam int unsigned SAMPLE_DIV = 12500;
   localparam int unsigned PWM_BITS   = 8;
   localparam int unsigned MIDSCALE   = 2 ** (PWM_BITS - 1);

   typedef logic [PWM_BITS-1:0] sample_t;

endpackage

// File: rtl/sample_pwm_dac_pwm_gen.sv
// Free-running PWM modulator; duty is reloaded only at the frame wrap so edges never glitch.
module sample_pwm_dac_pwm_gen (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [sample_pwm_dac_pkg::PWM_BITS-1:0] active,
   output logic                                   pwm_out
);
   import sample_pwm_dac_pkg::*;

   sample_t pwm_cnt;
   sample_t duty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         duty    <= sample_t'(MIDSCALE);
         pwm_out <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + sample_t'(1);
         if (pwm_cnt == '1) begin
            duty <= active;
         end
         pwm_out <= (pwm_cnt < duty);
      end
   end

endmodule

// File: rtl/sample_pwm_dac.sv
// Sample-period timer, hold/active double buffer, underrun flag and amplifier control
// in front of the PWM modulator.
module sample_pwm_dac #(
   parameter int unsigned SAMPLE_DIV = sample_pwm_dac_pkg::SAMPLE_DIV
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [sample_pwm_dac_pkg::PWM_BITS-1:0] sample_in,
   input  logic                                   sample_capture,
   input  logic                                   busy,
   input  logic                                   underrun_clr,
   output logic                                   period_expired,
   output logic                                   pwm_out,
   output logic                                   amp_en,
   output logic                                   underrun
);
   import sample_pwm_dac_pkg::*;

   localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam sample_t     MID   = sample_t'(MIDSCALE);

   logic [CNT_W-1:0] period_cnt;
   sample_t          hold;
   sample_t          active;
   logic             hold_valid;
   logic             underrun_set_c;

   // A boundary with nothing fresh while an utterance runs is an underrun.
   assign underrun_set_c = period_expired & ~hold_valid & busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt     <= '0;
         period_expired <= 1'b0;
      end else begin
         period_expired <= (period_cnt == CNT_W'(SAMPLE_DIV - 1));
         if (period_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
            period_cnt <= '0;
         end else begin
            period_cnt <= period_cnt + CNT_W'(1);
         end
      end
   end

   // Transfer reads pre-edge hold; a coincident capture refills hold for the next period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold       <= MID;
         hold_valid <= 1'b0;
         active     <= MID;
      end else begin
         if (sample_capture) begin
            hold       <= sample_in;
            hold_valid <= 1'b1;
         end else if (period_expired) begin
            hold_valid <= 1'b0;
         end
         if (period_expired) begin
            if (hold_valid) begin
               active <= hold;
            end else if (!busy) begin
               active <= MID;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun <= 1'b0;
         amp_en   <= 1'b0;
      end else begin
         if (underrun_set_c) begin
            underrun <= 1'b1;
         end else if (underrun_clr) begin
            underrun <= 1'b0;
         end
         if (busy) begin
            amp_en <= 1'b1;
         end else if (period_expired) begin
            amp_en <= 1'b0;
         end
      end
   end

   sample_pwm_dac_pwm_gen u_pwm_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .active  (active),
      .pwm_out (pwm_out)
   );

endmodule

// File: tb/tb_sample_pwm_dac.sv
// Bench for sample_pwm_dac: directed scenarios plus random captures against a sample-level model;
// PWM is judged by counting high clocks per 256-clock frame.
module tb_sample_pwm_dac;

   localparam int unsigned DIV   = 600;
   localparam int unsigned FRAME = 256;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] sample_in;
   logic       sample_capture;
   logic       busy;
   logic       underrun_clr;
   logic       period_expired;
   logic       pwm_out;
   logic       amp_en;
   logic       underrun;

   int errors = 0;
   int checks = 0;

   // Reference model state, updated once per clock from the behavioural rules.
   logic [7:0] m_hold, m_active, frame_duty;
   logic       m_hv, m_under, m_amp, m_pe;
   int         cyc;
   int         pwm_sum;

   sample_pwm_dac #(.SAMPLE_DIV(DIV)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sample_in      (sample_in),
      .sample_capture (sample_capture),
      .busy           (busy),
      .underrun_clr   (underrun_clr),
      .period_expired (period_expired),
      .pwm_out        (pwm_out),
      .amp_en         (amp_en),
      .underrun       (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_hold     = 8'h80;
      m_hv       = 1'b0;
      m_active   = 8'h80;
      m_under    = 1'b0;
      m_amp      = 1'b0;
      m_pe       = 1'b0;
      cyc        = 0;
      pwm_sum    = 0;
      frame_duty = 8'h80;
   endtask

   // One clock: apply the sample-buffer rules to the inputs now driven, then compare.
   task automatic tick();
      logic [7:0] act_pre;
      logic       set_u;
      act_pre = m_active;
      set_u   = 1'b0;
      if (m_pe) begin
         if (m_hv) begin
            m_active = m_hold;
            m_hv     = 1'b0;
         end else if (busy) begin
            set_u = 1'b1;
         end else begin
            m_active = 8'h80;
         end
      end
      if (sample_capture) begin
         m_hold = sample_in;
         m_hv   = 1'b1;
      end
      if (set_u)             m_under = 1'b1;
      else if (underrun_clr) m_under = 1'b0;
      if (busy)      m_amp = 1'b1;
      else if (m_pe) m_amp = 1'b0;

      @(posedge clk);
      #1;
      cyc++;
      m_pe    = ((cyc % DIV) == 0);
      pwm_sum += int'(pwm_out);
      check("period_expired", 32'(period_expired), 32'(m_pe));
      check("amp_en", 32'(amp_en), 32'(m_amp));
      check("underrun", 32'(underrun), 32'(m_under));
      check("active", 32'(dut.active), 32'(m_active));
      if ((cyc % FRAME) == 0) begin
         check("pwm_frame_high", 32'(pwm_sum), 32'(frame_duty));
         frame_duty = act_pre;
         pwm_sum    = 0;
      end
   endtask

   task automatic run_to(input int off);
      while ((cyc % DIV) != off) tick();
   endtask

   task automatic capture(input logic [7:0] v);
      sample_capture = 1'b1;
      sample_in      = v;
      tick();
      sample_capture = 1'b0;
      sample_in      = 8'h00;
   endtask

   initial begin
      int n;
      rst_n          = 1'b0;
      sample_in      = 8'h00;
      sample_capture = 1'b0;
      busy           = 1'b0;
      underrun_clr   = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_pwm_out", 32'(pwm_out), 32'd0);
      check("rst_amp_en", 32'(amp_en), 32'd0);
      check("rst_period_expired", 32'(period_expired), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_active", 32'(dut.active), 32'h80);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle: ticks at 600/1200/1800, midscale PWM, amplifier off
      repeat (1810) tick();

      // Single sample 0x40
      busy = 1'b1;
      run_to(100);
      capture(8'h40);
      run_to(0);
      tick();
      check("single_active", 32'(dut.active), 32'h40);

      // Extremes 0x00 then 0xFF
      run_to(100);
      capture(8'h00);
      run_to(100);
      capture(8'hFF);
      run_to(100);

      // Underrun through a tick, then clear
      run_to(0);
      tick();
      check("underrun_set", 32'(underrun), 32'd1);
      check("underrun_hold_active", 32'(dut.active), 32'hFF);
      run_to(200);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      check("underrun_cleared", 32'(underrun), 32'd0);

      // Clear coinciding with a new underrun: set wins
      run_to(0);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      check("underrun_set_wins", 32'(underrun), 32'd1);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;

      // Collision: capture 0x10 on the tick cycle while 0x20 is held
      run_to(100);
      capture(8'h20);
      run_to(0);
      capture(8'h10);
      check("collision_active", 32'(dut.active), 32'h20);
      check("collision_hold", 32'(dut.hold), 32'h10);
      run_to(0);
      tick();
      check("collision_next", 32'(dut.active), 32'h10);

      // Random captures, occasional skips and clears
      for (int p = 0; p < 6; p++) begin
         run_to($urandom_range(10, 500));
         if ($urandom_range(0, 3) != 0) capture(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 1) begin
            underrun_clr = 1'b1;
            tick();
            underrun_clr = 1'b0;
         end
         run_to(0);
         tick();
      end

      // Shutdown: amplifier holds until the next tick, then idle midscale
      run_to(300);
      busy = 1'b0;
      check("shutdown_amp_still_on", 32'(amp_en), 32'd1);
      run_to(0);
      tick();
      run_to(0);
      tick();
      check("shutdown_amp_off", 32'(amp_en), 32'd0);
      check("shutdown_active_mid", 32'(dut.active), 32'h80);

      // Asynchronous reset mid-frame while the output is high
      busy = 1'b1;
      run_to(100);
      capture(8'hC0);
      run_to(0);
      repeat (400) tick();
      n = 0;
      while (!(pwm_out === 1'b1) && n < 256) begin
         tick();
         n++;
      end
      check("pre_reset_pwm_high", 32'(pwm_out), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_pwm_out", 32'(pwm_out), 32'd0);
      check("async_rst_amp_en", 32'(amp_en), 32'd0);
      check("async_rst_active", 32'(dut.active), 32'h80);
      busy = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (610) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
